// File: rtl/alu_mul_sequencer.sv
// rtl/alu_mul_sequencer.sv - shift-and-add multiply sequencer that borrows the shared ALU
// Passes core ALU traffic through when idle; owns the ALU adder while a multiply runs.
module alu_mul_sequencer #(
  parameter int         WIDTH   = 32,
  parameter logic [2:0] ALU_ADD = 3'b000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] CoreSrcA,
  input  logic [WIDTH-1:0] CoreSrcB,
  input  logic [2:0]       CoreALUControl,
  output logic [WIDTH-1:0] SrcA,
  output logic [WIDTH-1:0] SrcB,
  output logic [2:0]       ALUControl,
  input  logic [WIDTH-1:0] ALUResult,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    count_d  = count_q;
    result_d = result_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (Start) begin
          acc_d    = '0;
          mcand_d  = A;
          mplier_d = B;
          count_d  = '0;
          busy_d   = 1'b1;
          if (B != '0) begin
            state_d = RUN;
          end else begin
            state_d  = DONE;
            result_d = '0;
            done_d   = 1'b1;
          end
        end
      end
      RUN: begin
        acc_d    = ALUResult;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q + CW'(1);
        // Stop as soon as no multiplier bits remain above the one consumed now.
        if (mplier_q[WIDTH-1:1] == '0 || count_q == LAST) begin
          state_d  = DONE;
          result_d = ALUResult;
          done_d   = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      count_q  <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      count_q  <= count_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    SrcA       = CoreSrcA;
    SrcB       = CoreSrcB;
    ALUControl = CoreALUControl;
    case (state_q)
      RUN: begin
        SrcA       = acc_q;
        SrcB       = mplier_q[0] ? mcand_q : '0;
        ALUControl = ALU_ADD;
      end
      DONE: begin
        SrcA       = '0;
        SrcB       = '0;
        ALUControl = ALU_ADD;
      end
      default: ;
    endcase
  end

  assign Busy   = busy_q;
  assign Done   = done_q;
  assign Result = result_q;

endmodule
